servo_multi_ctrl: RTL

//  Multi-channel hobby-servo PWM controller with a shared frame timebase. Host writes per-channel

---
 rtl/servo_multi_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/servo_multi_ctrl.sv
// Multi-channel hobby-servo PWM controller: one shared frame counter, per-channel
// slew-limited positions latched into pulse widths at every frame boundary.
module servo_multi_ctrl #(
  parameter int unsigned CLK_FREQ  = 25_000_000,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned POS_W     = 8,
  parameter int unsigned FRAME_HZ  = 50,
  parameter int unsigned MIN_US    = 1000,
  parameter int unsigned MAX_US    = 2000,
  parameter int unsigned SLEW_STEP = 4,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [POS_W-1:0]  cmd_pos,
  output logic              cmd_err,
  input  logic [NUM_CH-1:0] enable,
  output logic              frame_start,
  output logic [NUM_CH-1:0] at_target,
  output logic [NUM_CH-1:0] servo_out
);

  localparam int unsigned FRAME_CYC = CLK_FREQ / FRAME_HZ;
  localparam int unsigned MIN_CYC   = (CLK_FREQ / 1_000_000) * MIN_US;
  localparam int unsigned MAX_CYC   = (CLK_FREQ / 1_000_000) * MAX_US;
  localparam int unsigned POS_MAX   = (2 ** POS_W) - 1;
  localparam int unsigned STEP_CYC  = (MAX_CYC - MIN_CYC) / POS_MAX;
  localparam int unsigned CENTRE    = 2 ** (POS_W - 1);

  function automatic logic [31:0] width_of(input logic [POS_W-1:0] p);
    return MIN_CYC + (32'(p) * STEP_CYC);
  endfunction

  // Move cur toward tgt by at most SLEW_STEP; landing exactly on tgt prevents overshoot.
  function automatic logic [POS_W-1:0] slew(input logic [POS_W-1:0] cur,
                                            input logic [POS_W-1:0] tgt);
    logic [POS_W-1:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (32'(diff) <= SLEW_STEP) ? tgt : cur + POS_W'(SLEW_STEP);
    end else begin
      diff = cur - tgt;
      return (32'(diff) <= SLEW_STEP) ? tgt : cur - POS_W'(SLEW_STEP);
    end
  endfunction

  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic              frame_start_q, frame_start_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              cmd_err_q, cmd_err_d;
  logic [POS_W-1:0]  target_q [NUM_CH];
  logic [POS_W-1:0]  target_d [NUM_CH];
  logic [POS_W-1:0]  cur_pos_q [NUM_CH];
  logic [POS_W-1:0]  cur_pos_d [NUM_CH];
  logic [31:0]       width_lat_q [NUM_CH];
  logic [31:0]       width_lat_d [NUM_CH];
  logic [NUM_CH-1:0] en_lat_q, en_lat_d;
  logic [NUM_CH-1:0] servo_out_q, servo_out_d;
  logic              boundary;
  logic              cmd_fire;
  logic              ch_ok;

  // With a power-of-two channel count every encodable index is a real channel.
  if ((2 ** CH_W) == NUM_CH) begin : g_all_valid
    assign ch_ok = 1'b1;
  end else begin : g_range_check
    assign ch_ok = (cmd_ch < CH_W'(NUM_CH));
  end

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign boundary = (frame_cnt_q == FRAME_CYC - 1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    frame_cnt_d   = boundary ? 32'd0 : frame_cnt_q + 32'd1;
    frame_start_d = (frame_cnt_d == 32'd0);
    cmd_ready_d   = 1'b1;
    cmd_err_d     = cmd_fire && !ch_ok;
    target_d      = target_q;
    cur_pos_d     = cur_pos_q;
    width_lat_d   = width_lat_q;
    en_lat_d      = en_lat_q;
    servo_out_d   = '0;

    if (boundary) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cur_pos_d[i]   = slew(cur_pos_q[i], target_q[i]);
        width_lat_d[i] = width_of(cur_pos_d[i]);
      end
      en_lat_d = enable;
    end

    // The slew above reads target_q, so a same-edge write lands for the following frame.
    if (cmd_fire && ch_ok) begin
      target_d[cmd_ch] = cmd_pos;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      servo_out_d[i] = en_lat_q[i] && (frame_cnt_q < width_lat_q[i]);
    end
  end

  always_comb begin
    at_target = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      at_target[i] = (cur_pos_q[i] == target_q[i]);
    end
  end

  // NOTE: the position and width arrays are a handful of flops, not a RAM, so they take
  // the async reset like every other register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      cmd_err_q     <= 1'b0;
      en_lat_q      <= '0;
      servo_out_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i]    <= POS_W'(CENTRE);
        cur_pos_q[i]   <= POS_W'(CENTRE);
        width_lat_q[i] <= width_of(POS_W'(CENTRE));
      end
    end else begin
      // NOTE: non-blocking assignments only, so every register samples pre-edge values.
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
      cmd_ready_q   <= cmd_ready_d;
      cmd_err_q     <= cmd_err_d;
      target_q      <= target_d;
      cur_pos_q     <= cur_pos_d;
      width_lat_q   <= width_lat_d;
      en_lat_q      <= en_lat_d;
      servo_out_q   <= servo_out_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign cmd_err     = cmd_err_q;
  assign frame_start = frame_start_q;
  assign servo_out   = servo_out_q;

endmodule
